jtcps1_vram_arb: RTL and testbench
==================================

# jtcps1_vram_arb

Responder side of the CPS1 video VRAM read protocol. It serves the three video requesters (scroll, object, palette), each with its own addr/cs/data/ok port, from one shared memory read port. A round-robin arbiter grants one request at a time. A per-client address latch holds `ok` asserted for as long as the requester keeps its address stable.

## Interface
- No parameters.
- `clk` in 1: system clock; all logic on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `scr_addr` in 17 [17:1]: scroll word address.
- `scr_cs` in 1: scroll request.
- `scr_data` out 16: scroll read data.
- `scr_ok` out 1: scroll data valid.
- `obj_addr`, `obj_cs`, `obj_data`, `obj_ok`: same as the scroll set, for the object client.
- `pal_addr`, `pal_cs`, `pal_data`, `pal_ok`: same as the scroll set, for the palette client.
- `mem_addr` out 17: address presented to memory.
- `mem_rd` out 1: read request, held until acknowledged.
- `mem_ack` in 1: one-cycle pulse; memory has taken the request.
- `mem_dok` in 1: one-cycle pulse; `mem_data` is valid.
- `mem_data` in 16: memory read data.
- `cpu_wr` in 1: CPU VRAM write strobe.
- `cpu_addr` in 17: CPU write word address.

## Operation
- Each client i (0 = scr, 1 = obj, 2 = pal) keeps three registers: `lat_addr_i` (17 bits), `data_i` (16 bits) and `valid_i` (1 bit).
- `ok_i = cs_i & valid_i & (addr_i == lat_addr_i)`. This is combinational, so `ok_i` falls in the same cycle the address changes or `cs_i` drops.
- A client is pending when `cs_i` is high and it is not hit (`ok_i` low).
- FSM states:
  - **IDLE**: if any client is pending, grant the first pending client at or after `rr_ptr`, in cyclic order 0→1→2. Latch the granted index and the client's address into `mem_addr`, then go to **REQ**.
  - **REQ**: `mem_rd` = 1. When `mem_ack` = 1, go to **WAIT**.
  - **WAIT**: when `mem_dok` = 1, write `lat_addr_g` ← granted address, `data_g` ← `mem_data`, `valid_g` ← 1. Set `rr_ptr` ← g+1 mod 3, then go to **IDLE**.
- A granted client may change its address or drop `cs` mid-transaction. The transaction still completes and fills the latch with the originally granted address. `ok_g` then stays low because the address no longer matches, and the client becomes pending again.
- Invalidation: `cpu_wr` = 1 with `cpu_addr == lat_addr_i` clears `valid_i`, for each client.
  - If `cpu_wr` hits the granted address in the same cycle as `mem_dok`, `valid_g` ends at 0; clear takes priority.
  - A CPU write during **REQ** or **WAIT** to the in-flight address marks the fill stale, so `valid_g` stays 0 after **WAIT**.
- Reset values: state **IDLE**, `rr_ptr` = 0, all `valid_i` = 0, all `lat_addr_i` = 0, all `data_i` = 0, `mem_rd` = 0, `mem_addr` = 0. Every `*_ok` output is 0.
- Asynchronous reset mid-transaction drops `mem_rd` immediately. The `mem_ack`/`mem_dok` for the abandoned access are ignored, because the FSM is in **IDLE** after reset.
- `mem_ack` or `mem_dok` arriving outside **REQ** or **WAIT** respectively is ignored.

## Timing
- Miss latency:
  - `cs` with new address sampled at edge N.
  - `mem_rd` high after edge N+1.
  - Earliest `mem_ack` seen at edge N+2; earliest `mem_dok` at N+3.
  - `ok` high after edge N+3.
  - Each extra memory wait cycle adds one cycle.
- Hit latency: 0 cycles. `ok` rises combinationally when `cs` rises with the latched address and `valid` is set.
- Only one outstanding memory access at a time. Back-to-back grants are separated by one **IDLE** cycle.
- Fairness: with all three clients continuously missing, grants follow scr, obj, pal, scr, and so on. No client waits more than two other transactions.
- `mem_addr` is stable from entry into **REQ** until the exit from **WAIT**.

## Configuration
- `JTCPS1_VRAM_HIT_EN` defined: latch-hit behaviour as described above.
- Undefined:
  - `valid_i` is also cleared when `cs_i` falls.
  - Every new `cs` assertion, even with the same address, triggers a memory access.
  - `ok` still holds while `cs` and the address stay stable.
  - All other behaviour is unchanged.

## Test plan
- Reset, then `scr_cs` = 1 with `scr_addr` = 0x00100; memory acks after 1 cycle and sends dok = 0xBEEF 2 cycles later -> `mem_addr` = 0x00100, `scr_data` = 0xBEEF, `scr_ok` high after edge N+4; `obj_ok` and `pal_ok` stay 0.
- All three clients request distinct addresses (0x10, 0x20, 0x30) in the same cycle -> `mem_addr` sequence 0x10, 0x20, 0x30; each `ok` rises only after its own dok.
- With scr hit on 0x10, drop `scr_cs` and re-raise it with 0x10 -> with `HIT_EN`, `scr_ok` is high the same cycle and no `mem_rd`; without it, one new `mem_rd` is issued.
- Change `obj_addr` 0x20→0x21 while in **WAIT** for 0x20 -> `obj_ok` stays 0 after dok; a second access to 0x21 follows and `obj_ok` = 1 with the new data.
- `pal` hit on 0x30, then `cpu_wr` with `cpu_addr` = 0x30 -> `pal_ok` drops next cycle and a refetch of 0x30 is issued; `cpu_wr` with 0x31 leaves `pal_ok` high.
- Assert `rstn` = 0 in **WAIT**, then release, then send a stray `mem_dok` -> `mem_rd` = 0, all `ok` = 0, no latch is updated.

Source files
------------

// File: rtl/jtcps1_vram_arb.sv
// Round-robin arbiter serving the CPS1 scroll/object/palette VRAM readers from one memory read port.
// Define JTCPS1_VRAM_HIT_EN to let a re-raised cs hit its latched address without a new memory access.
module jtcps1_vram_arb (
    input  logic        clk,
    input  logic        rstn,
    input  logic [17:1] scr_addr,
    input  logic        scr_cs,
    output logic [15:0] scr_data,
    output logic        scr_ok,
    input  logic [17:1] obj_addr,
    input  logic        obj_cs,
    output logic [15:0] obj_data,
    output logic        obj_ok,
    input  logic [17:1] pal_addr,
    input  logic        pal_cs,
    output logic [15:0] pal_data,
    output logic        pal_ok,
    output logic [17:1] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic        mem_dok,
    input  logic [15:0] mem_data,
    input  logic        cpu_wr,
    input  logic [17:1] cpu_addr
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    state_t      state;
    logic [1:0]  rr_ptr, gnt, pick, c1, c2;
    logic        stale, cpu_hit_inflight, any_req;
    logic [2:0]  cs_in, ok, pend, pend_reg, req;
    logic [17:1] addr_in  [3];
    logic [15:0] data_lat [3];

    assign cs_in      = {pal_cs, obj_cs, scr_cs};
    assign addr_in[0] = scr_addr;
    assign addr_in[1] = obj_addr;
    assign addr_in[2] = pal_addr;

    assign scr_ok   = ok[0];
    assign obj_ok   = ok[1];
    assign pal_ok   = ok[2];
    assign scr_data = data_lat[0];
    assign obj_data = data_lat[1];
    assign pal_data = data_lat[2];

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Requests go through one register stage; AND with the live pending
    // bit so a client that turned into a hit or dropped cs is not granted.
    assign req              = pend & pend_reg;
    assign any_req          = |req;
    assign c1               = next_idx(rr_ptr);
    assign c2               = next_idx(c1);
    assign cpu_hit_inflight = cpu_wr && (cpu_addr == mem_addr);

    always_comb begin
        pick = c2;
        if (req[rr_ptr])
            pick = rr_ptr;
        else if (req[c1])
            pick = c1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_client
            logic [17:1] lat_addr_reg;
            logic [15:0] data_reg;
            logic        valid_reg, fill, drop;

            assign fill = (state == ST_WAIT) && mem_dok && (gnt == 2'(gi));
`ifdef JTCPS1_VRAM_HIT_EN
            assign drop = 1'b0;
`else
            assign drop = ~cs_in[gi];
`endif
            // CPU write invalidation wins over a fill landing in the same cycle.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    lat_addr_reg <= '0;
                    data_reg     <= '0;
                    valid_reg    <= 1'b0;
                end else if (fill) begin
                    lat_addr_reg <= mem_addr;
                    data_reg     <= mem_data;
                    valid_reg    <= ~stale & ~cpu_hit_inflight & ~drop;
                end else if (drop || (cpu_wr && cpu_addr == lat_addr_reg)) begin
                    valid_reg    <= 1'b0;
                end
            end

            assign data_lat[gi] = data_reg;
            assign ok[gi]       = cs_in[gi] & valid_reg & (addr_in[gi] == lat_addr_reg);
            assign pend[gi]     = cs_in[gi] & ~ok[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            rr_ptr   <= 2'd0;
            gnt      <= 2'd0;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            stale    <= 1'b0;
            pend_reg <= 3'd0;
        end else begin
            pend_reg <= pend;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt      <= pick;
                        mem_addr <= addr_in[pick];
                        mem_rd   <= 1'b1;
                        stale    <= 1'b0;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (cpu_hit_inflight)
                        stale <= 1'b1;
                    if (mem_ack) begin
                        mem_rd <= 1'b0;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cpu_hit_inflight)
                        stale <= 1'b1;
                    if (mem_dok) begin
                        rr_ptr <= next_idx(gnt);
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtcps1_vram_arb.sv
// Directed bench for jtcps1_vram_arb; expectations follow the build mode of JTCPS1_VRAM_HIT_EN.
module tb_jtcps1_vram_arb;
    logic        clk, rstn;
    logic [17:1] scr_addr, obj_addr, pal_addr, mem_addr, cpu_addr;
    logic        scr_cs, obj_cs, pal_cs, scr_ok, obj_ok, pal_ok;
    logic [15:0] scr_data, obj_data, pal_data, mem_data;
    logic        mem_rd, mem_ack, mem_dok, cpu_wr;
    int          n_checks = 0;
    int          n_fail = 0;

    jtcps1_vram_arb dut (
        .clk(clk), .rstn(rstn),
        .scr_addr(scr_addr), .scr_cs(scr_cs), .scr_data(scr_data), .scr_ok(scr_ok),
        .obj_addr(obj_addr), .obj_cs(obj_cs), .obj_data(obj_data), .obj_ok(obj_ok),
        .pal_addr(pal_addr), .pal_cs(pal_cs), .pal_data(pal_data), .pal_ok(pal_ok),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_dok(mem_dok),
        .mem_data(mem_data), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rd(input logic [17:1] ea, input string tag);
        int n = 0;
        while (mem_rd !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_rd"}, 32'(mem_rd), 32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), 32'(ea));
    endtask

    task automatic ack();
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic dok(input logic [15:0] d);
        mem_data = d;
        mem_dok  = 1'b1;
        tick();
        mem_dok  = 1'b0;
    endtask

    task automatic serve(input logic [17:1] ea, input logic [15:0] d, input string tag);
        wait_rd(ea, tag);
        ack();
        tick();
        dok(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        {scr_cs, obj_cs, pal_cs, mem_ack, mem_dok, cpu_wr} = '0;
        scr_addr = '0; obj_addr = '0; pal_addr = '0; cpu_addr = '0; mem_data = '0;
        tick(); tick();
        rstn = 1'b1;
        tick();
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_ok", 32'({scr_ok, obj_ok, pal_ok}), 32'd0);
        chk("rst_data", 32'(scr_data), 32'd0);

        // Single scroll miss: mem_rd one edge after the sampling edge
        scr_cs = 1'b1; scr_addr = 17'h00100;
        tick();
        chk("t1_no_rd_yet", 32'(mem_rd), 32'd0);
        tick();
        chk("t1_rd", 32'(mem_rd), 32'd1);
        chk("t1_addr", 32'(mem_addr), 32'h100);
        ack();
        chk("t1_rd_dropped", 32'(mem_rd), 32'd0);
        tick();
        chk("t1_ok_before_dok", 32'(scr_ok), 32'd0);
        dok(16'hBEEF);
        chk("t1_ok", 32'(scr_ok), 32'd1);
        chk("t1_data", 32'(scr_data), 32'hBEEF);
        chk("t1_others", 32'({obj_ok, pal_ok}), 32'd0);

        // Three simultaneous misses served in round-robin order from reset
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        scr_addr = 17'h10; obj_addr = 17'h20; pal_addr = 17'h30;
        obj_cs = 1'b1; pal_cs = 1'b1;
        serve(17'h10, 16'hA010, "t2_scr");
        chk("t2_ok_after_scr", 32'({scr_ok, obj_ok, pal_ok}), 32'b100);
        serve(17'h20, 16'hA020, "t2_obj");
        chk("t2_ok_after_obj", 32'({scr_ok, obj_ok, pal_ok}), 32'b110);
        serve(17'h30, 16'hA030, "t2_pal");
        chk("t2_ok_after_pal", 32'({scr_ok, obj_ok, pal_ok}), 32'b111);
        chk("t2_pal_data", 32'(pal_data), 32'hA030);

        // Drop and re-raise scr_cs on the same address
        scr_cs = 1'b0;
        tick();
        scr_cs = 1'b1;
        #1;
`ifdef JTCPS1_VRAM_HIT_EN
        chk("t3_hit_ok", 32'(scr_ok), 32'd1);
        tick(); tick(); tick();
        chk("t3_no_rd", 32'(mem_rd), 32'd0);
`else
        chk("t3_miss_ok", 32'(scr_ok), 32'd0);
        serve(17'h10, 16'hC010, "t3_refetch");
        chk("t3_ok", 32'(scr_ok), 32'd1);
        chk("t3_data", 32'(scr_data), 32'hC010);
`endif

        // Object address changes while its fetch is in WAIT
        cpu_wr = 1'b1; cpu_addr = 17'h20;
        tick();
        cpu_wr = 1'b0;
        chk("t4_inval", 32'(obj_ok), 32'd0);
        wait_rd(17'h20, "t4_first");
        ack();
        obj_addr = 17'h21;
        tick();
        dok(16'hD020);
        chk("t4_stale_ok", 32'(obj_ok), 32'd0);
        chk("t4_stale_data", 32'(obj_data), 32'hD020);
        serve(17'h21, 16'hD021, "t4_second");
        chk("t4_ok", 32'(obj_ok), 32'd1);
        chk("t4_data", 32'(obj_data), 32'hD021);

        // CPU writes: miss leaves the hit alone, match forces a refetch
        chk("t5_pal_hit", 32'(pal_ok), 32'd1);
        cpu_wr = 1'b1; cpu_addr = 17'h31;
        tick();
        cpu_wr = 1'b0;
        chk("t5_other_wr_ok", 32'(pal_ok), 32'd1);
        cpu_wr = 1'b1; cpu_addr = 17'h30;
        tick();
        cpu_wr = 1'b0;
        chk("t5_wr_drop", 32'(pal_ok), 32'd0);
        serve(17'h30, 16'hE030, "t5_refetch");
        chk("t5_ok", 32'(pal_ok), 32'd1);
        chk("t5_data", 32'(pal_data), 32'hE030);

        // CPU write to the in-flight address during WAIT makes the fill stale
        cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        wait_rd(17'h30, "t5b_fetch");
        ack();
        cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        dok(16'hE031);
        chk("t5b_stale_ok", 32'(pal_ok), 32'd0);
        serve(17'h30, 16'hE032, "t5b_refetch");
        chk("t5b_ok", 32'(pal_ok), 32'd1);
        chk("t5b_data", 32'(pal_data), 32'hE032);

        // Asynchronous reset mid-transaction, then stray memory pulses
        scr_addr = 17'h40;
        wait_rd(17'h40, "t6_fetch");
        #2 rstn = 1'b0;
        #1;
        chk("t6_async_rd", 32'(mem_rd), 32'd0);
        scr_cs = 1'b0; obj_cs = 1'b0; pal_cs = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        mem_ack = 1'b1;
        dok(16'h5555);
        mem_ack = 1'b0;
        chk("t6_stray_rd", 32'(mem_rd), 32'd0);
        scr_cs = 1'b1; scr_addr = 17'h0;
        #1;
        chk("t6_stray_ok", 32'(scr_ok), 32'd0);
        chk("t6_stray_data", 32'(scr_data), 32'd0);
        wait_rd(17'h0, "t6_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
